nios_mtl_mem_copier: RTL and testbench

- Avalon-MM master that copies a block of 32-bit words from one word address to another in the on-chip memory, one word at a time (read, then write).
- Connects through the system interconnect to the on-chip memory slave port (13-bit word address, 4-bit byteenable).
- Control side is a simple start/busy/done interface driven by a Nios-side register block.

---
 rtl/nios_mtl_mem_copier.sv | 147 ++++++++++++++
 tb/tb_nios_mtl_mem_copier.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_mtl_mem_copier.sv
// Avalon-MM master that copies a block of 32-bit words one at a time (read, then write).
// Optional constant-fill mode is compiled in with `define MEM_COPIER_FILL_EN.
module nios_mtl_mem_copier #(
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned LEN_W  = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
`ifdef MEM_COPIER_FILL_EN
    input  logic              fill_mode,
    input  logic [31:0]       fill_value,
`endif
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [LEN_W-1:0]  words_done,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_read,
    output logic              m_write,
    output logic [3:0]        m_byteenable,
    output logic [31:0]       m_writedata,
    input  logic [31:0]       m_readdata,
    input  logic              m_readdatavalid,
    input  logic              m_waitrequest
);

    typedef enum logic [2:0] {StIdle, StRd, StRdw, StWr, StDone} state_t;

    state_t            state;
    logic [ADDR_W-1:0] src_cur;
    logic [ADDR_W-1:0] dst_cur;
    logic [LEN_W-1:0]  remaining;
    logic              abort_seen;
    logic              fill_q;
    logic              start_fill;
    logic [31:0]       start_word;
    logic              stop_now;

`ifdef MEM_COPIER_FILL_EN
    assign start_fill = fill_mode;
    assign start_word = fill_value;
`else
    assign start_fill = 1'b0;
    assign start_word = 32'h0;
`endif

    assign m_byteenable = 4'hF;
    // Abort seen during the read half of a word is honoured only once that word's write lands.
    assign stop_now = (remaining == LEN_W'(1)) || abort || abort_seen;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= StIdle;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            words_done  <= '0;
            m_address   <= '0;
            m_read      <= 1'b0;
            m_write     <= 1'b0;
            m_writedata <= '0;
            src_cur     <= '0;
            dst_cur     <= '0;
            remaining   <= '0;
            abort_seen  <= 1'b0;
            fill_q      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        words_done <= '0;
                        aborted    <= 1'b0;
                        abort_seen <= 1'b0;
                        if (length == '0) begin
                            done <= 1'b1;
                        end else begin
                            busy      <= 1'b1;
                            src_cur   <= src_addr;
                            dst_cur   <= dst_addr;
                            remaining <= length;
                            fill_q    <= start_fill;
                            if (start_fill) begin
                                state       <= StWr;
                                m_write     <= 1'b1;
                                m_address   <= dst_addr;
                                m_writedata <= start_word;
                            end else begin
                                state     <= StRd;
                                m_read    <= 1'b1;
                                m_address <= src_addr;
                            end
                        end
                    end
                end
                StRd: begin
                    if (abort) abort_seen <= 1'b1;
                    if (!m_waitrequest) begin
                        m_read <= 1'b0;
                        state  <= StRdw;
                    end
                end
                StRdw: begin
                    if (abort) abort_seen <= 1'b1;
                    if (m_readdatavalid) begin
                        m_writedata <= m_readdata;
                        m_write     <= 1'b1;
                        m_address   <= dst_cur;
                        state       <= StWr;
                    end
                end
                StWr: begin
                    if (!m_waitrequest) begin
                        src_cur    <= src_cur + ADDR_W'(1);
                        dst_cur    <= dst_cur + ADDR_W'(1);
                        words_done <= words_done + LEN_W'(1);
                        remaining  <= remaining - LEN_W'(1);
                        if (stop_now) begin
                            m_write <= 1'b0;
                            aborted <= (remaining != LEN_W'(1));
                            state   <= StDone;
                        end else if (fill_q) begin
                            m_address <= dst_cur + ADDR_W'(1);
                        end else begin
                            m_write   <= 1'b0;
                            m_read    <= 1'b1;
                            m_address <= src_cur + ADDR_W'(1);
                            state     <= StRd;
                        end
                    end
                end
                StDone: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_nios_mtl_mem_copier.sv
// Scoreboard bench for nios_mtl_mem_copier: a memory slave model, a reference copy model,
// and a negedge monitor that pops expected bus transactions and completions.
module tb_nios_mtl_mem_copier;
    localparam int MEM_WORDS = 8192;

    logic        clk = 1'b0;
    logic        reset, start, abort;
    logic [12:0] src_addr, dst_addr;
    logic [13:0] length;
`ifdef MEM_COPIER_FILL_EN
    logic        fill_mode;
    logic [31:0] fill_value;
`endif
    logic        busy, done, aborted;
    logic [13:0] words_done;
    logic [12:0] m_address;
    logic        m_read, m_write, m_readdatavalid, m_waitrequest;
    logic [3:0]  m_byteenable;
    logic [31:0] m_writedata, m_readdata;

    nios_mtl_mem_copier #(.ADDR_W(13), .LEN_W(14)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
`ifdef MEM_COPIER_FILL_EN
        .fill_mode(fill_mode), .fill_value(fill_value),
`endif
        .busy(busy), .done(done), .aborted(aborted), .words_done(words_done),
        .m_address(m_address), .m_read(m_read), .m_write(m_write),
        .m_byteenable(m_byteenable), .m_writedata(m_writedata), .m_readdata(m_readdata),
        .m_readdatavalid(m_readdatavalid), .m_waitrequest(m_waitrequest)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    logic [31:0] mem     [MEM_WORDS];
    logic [31:0] ref_mem [MEM_WORDS];
    logic [12:0] exp_rd[$];
    logic [44:0] exp_wr[$];   // {address, data}
    logic [14:0] exp_done[$]; // {words_done, aborted}

    // Slave model knobs and state
    int          ws = 0;
    int          lat = 1;
    int          stall_cnt = 0;
    int          rd_cnt = 0;
    logic [31:0] rd_data = '0;
    logic [31:0] stray_data = '0;
    logic        stray = 1'b0;
    logic        stall_prev = 1'b0;
    logic [46:0] stall_snap = '0;
    logic [44:0] e_wr;
    logic [14:0] e_done;

    assign m_waitrequest   = (m_read || m_write) && (stall_cnt < ws);
    assign m_readdatavalid = (rd_cnt == 1) || stray;
    assign m_readdata      = (rd_cnt == 1) ? rd_data : stray_data;

    always @(posedge clk) begin
        if ((m_read || m_write) && m_waitrequest) stall_cnt <= stall_cnt + 1;
        else stall_cnt <= 0;
        if (m_read && !m_waitrequest) rd_cnt <= lat;
        else if (rd_cnt != 0) rd_cnt <= rd_cnt - 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [63:0] act);
        compared++;
        mismatched++;
        $display("FAIL %s: got %0h, required none", name, act);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Monitor: bus accepts happen at the posedge following a negedge where request && !wait.
    always @(negedge clk) begin
        if (reset) begin
            stall_prev = 1'b0;
            stray      = 1'b0;
        end else begin
            if (m_read && m_write) fail_now("rw_exclusive", 64'(m_address));
            if (stall_prev)
                check("stall_stable", 64'({m_address, m_read, m_write, m_writedata}),
                      64'(stall_snap));
            stall_prev = (m_read || m_write) && m_waitrequest;
            stall_snap = {m_address, m_read, m_write, m_writedata};
            if (m_read && !m_waitrequest) begin
                if (exp_rd.size() == 0) fail_now("unexpected_read", 64'(m_address));
                else check("read_addr", 64'(m_address), 64'(exp_rd.pop_front()));
                rd_data = mem[m_address];
            end
            if (m_write && !m_waitrequest) begin
                if (exp_wr.size() == 0) begin
                    fail_now("unexpected_write", 64'(m_address));
                end else begin
                    e_wr = exp_wr.pop_front();
                    check("write_addr", 64'(m_address), 64'(e_wr[44:32]));
                    check("write_data", 64'(m_writedata), 64'(e_wr[31:0]));
                end
                mem[m_address] = m_writedata;
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    fail_now("unexpected_done", 64'(words_done));
                end else begin
                    e_done = exp_done.pop_front();
                    check("done_words", 64'(words_done), 64'(e_done[14:1]));
                    check("done_aborted", 64'(aborted), 64'(e_done[0]));
                end
                check("done_busy_low", 64'(busy), 64'(0));
            end
            // Junk read-valid pulses while no read is outstanding must be ignored.
            stray      = (rd_cnt == 0) && !m_read && ($urandom_range(7) == 0);
            stray_data = $urandom;
        end
    end

    // Reference model: ascending word-by-word copy with 13-bit address wrap.
    task automatic plan_copy(input logic [12:0] s, input logic [12:0] d, input int words,
                             input logic ab);
        for (int i = 0; i < words; i++) begin
            logic [12:0] a;
            logic [12:0] w;
            a = s + 13'(i);
            w = d + 13'(i);
            exp_rd.push_back(a);
            ref_mem[w] = ref_mem[a];
            exp_wr.push_back({w, ref_mem[w]});
        end
        exp_done.push_back({14'(words), ab});
    endtask

    task automatic start_op(input logic [12:0] s, input logic [12:0] d, input logic [13:0] n);
        src_addr = s;
        dst_addr = d;
        length   = n;
        start    = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 3000) begin
            tick();
            cyc++;
        end
        if (!done) fail_now("done_timeout", 64'(cyc));
    endtask

    int          cyc;
    int          n;
    int          diffs;
    logic [12:0] s, d;

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0;
        src_addr = '0; dst_addr = '0; length = '0;
`ifdef MEM_COPIER_FILL_EN
        fill_mode = 1'b0; fill_value = '0;
`endif
        for (int i = 0; i < MEM_WORDS; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        tick();
        tick();
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_aborted", 64'(aborted), 64'(0));
        check("rst_words_done", 64'(words_done), 64'(0));
        check("rst_m_read", 64'(m_read), 64'(0));
        check("rst_m_write", 64'(m_write), 64'(0));
        check("rst_m_address", 64'(m_address), 64'(0));
        check("rst_m_writedata", 64'(m_writedata), 64'(0));
        check("byteenable", 64'(m_byteenable), 64'(4'hF));
        reset = 1'b0;
        tick();

        // Basic copy, zero wait states, latency 1
        for (int i = 0; i < 4; i++) begin
            mem[16+i]     = 32'hA000_0000 + 32'(i);
            ref_mem[16+i] = 32'hA000_0000 + 32'(i);
        end
        ws = 0; lat = 1;
        plan_copy(13'h010, 13'h100, 4, 1'b0);
        start_op(13'h010, 13'h100, 14'd4);
        check("busy_after_start", 64'(busy), 64'(1));
        wait_done(cyc);
        check("copy_done_cycle", 64'(cyc), 64'(13));
        for (int i = 0; i < 4; i++)
            check("copy_mem", 64'(mem[256+i]), 64'(32'hA000_0000 + 32'(i)));

        // Stalls on every read and write
        ws = 3; lat = 2;
        plan_copy(13'h040, 13'h140, 2, 1'b0);
        start_op(13'h040, 13'h140, 14'd2);
        wait_done(cyc);

        // Source address wrap
        ws = 0; lat = 1;
        plan_copy(13'h1FFE, 13'h0500, 4, 1'b0);
        start_op(13'h1FFE, 13'h0500, 14'd4);
        wait_done(cyc);

        // Zero length
        plan_copy(13'h0, 13'h0, 0, 1'b0);
        start_op(13'h123, 13'h456, 14'd0);
        wait_done(cyc);
        check("zero_len_done_cycle", 64'(cyc), 64'(0));
        check("zero_len_busy", 64'(busy), 64'(0));

        // Start while busy is ignored
        plan_copy(13'h300, 13'h400, 6, 1'b0);
        start_op(13'h300, 13'h400, 14'd6);
        repeat (4) tick();
        start_op(13'h700, 13'h600, 14'd5);
        wait_done(cyc);
        repeat (10) tick();
        check("ignored_start_no_reads", 64'(exp_rd.size()), 64'(0));

        // Abort during third word's read wait
        ws = 0; lat = 3;
        plan_copy(13'h700, 13'h800, 3, 1'b1);
        start_op(13'h700, 13'h800, 14'd10);
        n = 0;
        while (words_done != 14'd2 && n < 200) begin tick(); n++; end
        while (!(m_read && !m_waitrequest) && n < 200) begin tick(); n++; end
        if (n >= 200) fail_now("abort_wait_timeout", 64'(n));
        tick();
        abort = 1'b1;
        wait_done(cyc);
        abort = 1'b0;
        check("abort_flag", 64'(aborted), 64'(1));
        check("abort_words", 64'(words_done), 64'(3));
        check("abort_mem", 64'(mem[13'h802]), 64'(ref_mem[13'h802]));

        // Reset while a write is stalled
        ws = 2; lat = 1;
        exp_rd.push_back(13'h900);
        start_op(13'h900, 13'hA00, 14'd5);
        n = 0;
        while (!m_write && n < 200) begin tick(); n++; end
        if (n >= 200) fail_now("wr_wait_timeout", 64'(n));
        reset = 1'b1;
        tick();
        check("reset_wr_drop", 64'(m_write), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        reset = 1'b0;
        n = 0;
        repeat (10) begin tick(); if (done) n++; end
        check("reset_no_done", 64'(n), 64'(0));

        // Randomized copies, including overlapping regions
        repeat (25) begin
            ws  = $urandom_range(2);
            lat = $urandom_range(3, 1);
            s   = 13'($urandom);
            d   = ($urandom_range(3) == 0) ? s + 13'($urandom_range(3)) : 13'($urandom);
            n   = $urandom_range(24, 1);
            plan_copy(s, d, n, 1'b0);
            start_op(s, d, 14'(n));
            wait_done(cyc);
        end

`ifdef MEM_COPIER_FILL_EN
        ws = 0;
        for (int i = 0; i < 8; i++) begin
            ref_mem[13'h200 + 13'(i)] = 32'hDEAD_BEEF;
            exp_wr.push_back({13'h200 + 13'(i), 32'hDEAD_BEEF});
        end
        exp_done.push_back({14'd8, 1'b0});
        fill_mode = 1'b1; fill_value = 32'hDEAD_BEEF;
        start_op(13'h1AB, 13'h200, 14'd8);
        fill_mode = 1'b0;
        wait_done(cyc);
        check("fill_done_cycle", 64'(cyc), 64'(9));
`endif

        repeat (3) tick();
        diffs = 0;
        for (int i = 0; i < MEM_WORDS; i++) if (mem[i] !== ref_mem[i]) diffs++;
        check("final_mem_diffs", 64'(diffs), 64'(0));
        check("rd_queue_empty", 64'(exp_rd.size()), 64'(0));
        check("wr_queue_empty", 64'(exp_wr.size()), 64'(0));
        check("done_queue_empty", 64'(exp_done.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
